// File: rtl/branch_resolve_unit.sv
// Two-stage branch/jump resolver: S0 captures the decode-side entry, S1 holds the
// resolved redirect (taken, target, link, misalignment) for fetch-redirect logic.
module branch_resolve_unit #(
  parameter int XLEN    = 32,
  parameter int JUMP_EN = 1,
  parameter int IALIGN  = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1_val,
  input  logic [XLEN-1:0]  in_rs2_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_link,
  output logic             out_is_branch,
  output logic             out_is_jump,
  output logic [2:0]       out_br_ctrl,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic             out_misaligned,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_taken
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Branch-control codes follow func3; the reserved func3 value 2 doubles as "no branch".
  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_NOP  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BLTU = 3'd6;
  localparam logic [2:0] BR_BGEU = 3'd7;

  logic             s0_valid_reg;
  logic [31:0]      s0_instr_reg;
  logic [XLEN-1:0]  s0_pc_reg, s0_rs1_reg, s0_rs2_reg;

  logic             s1_valid_reg, s1_taken_reg, s1_is_branch_reg, s1_is_jump_reg;
  logic             s1_illegal_reg, s1_misaligned_reg;
  logic [XLEN-1:0]  s1_target_reg, s1_link_reg;
  logic [2:0]       s1_br_ctrl_reg;
  logic [4:0]       s1_rs1_reg, s1_rs2_reg, s1_rd_reg;
  logic [CNT_W-1:0] cnt_branch_reg, cnt_taken_reg;

  logic             s1_load;
  logic [6:0]       opcode;
  logic [2:0]       func3;
  logic [XLEN-1:0]  imm_b, imm_j, imm_i, link_next, jalr_sum;
  logic [XLEN-1:0]  target_next;
  logic [2:0]       br_ctrl_next;
  logic             taken_next, is_branch_next, is_jump_next, illegal_next, misaligned_next;

  assign s1_load  = !s1_valid_reg || out_ready;
  assign in_ready = !s0_valid_reg || s1_load;

  assign opcode    = s0_instr_reg[6:0];
  assign func3     = s0_instr_reg[14:12];
  assign imm_b     = {{(XLEN-13){s0_instr_reg[31]}}, s0_instr_reg[31], s0_instr_reg[7],
                      s0_instr_reg[30:25], s0_instr_reg[11:8], 1'b0};
  assign imm_j     = {{(XLEN-21){s0_instr_reg[31]}}, s0_instr_reg[31], s0_instr_reg[19:12],
                      s0_instr_reg[20], s0_instr_reg[30:21], 1'b0};
  assign imm_i     = {{(XLEN-12){s0_instr_reg[31]}}, s0_instr_reg[31:20]};
  assign link_next = s0_pc_reg + XLEN'(4);
  assign jalr_sum  = s0_rs1_reg + imm_i;

  always_comb begin
    taken_next     = 1'b0;
    is_branch_next = 1'b0;
    is_jump_next   = 1'b0;
    illegal_next   = 1'b0;
    br_ctrl_next   = BR_NOP;
    target_next    = link_next;
    if (opcode == OP_BRANCH) begin
      is_branch_next = 1'b1;
      case (func3)
        3'd0: begin br_ctrl_next = BR_BEQ;  taken_next = (s0_rs1_reg == s0_rs2_reg); end
        3'd1: begin br_ctrl_next = BR_BNE;  taken_next = (s0_rs1_reg != s0_rs2_reg); end
        3'd4: begin br_ctrl_next = BR_BLT;  taken_next = ($signed(s0_rs1_reg) <  $signed(s0_rs2_reg)); end
        3'd5: begin br_ctrl_next = BR_BGE;  taken_next = ($signed(s0_rs1_reg) >= $signed(s0_rs2_reg)); end
        3'd6: begin br_ctrl_next = BR_BLTU; taken_next = (s0_rs1_reg <  s0_rs2_reg); end
        3'd7: begin br_ctrl_next = BR_BGEU; taken_next = (s0_rs1_reg >= s0_rs2_reg); end
        default: illegal_next = 1'b1;
      endcase
      if (taken_next) target_next = s0_pc_reg + imm_b;
    end else if (JUMP_EN != 0 && opcode == OP_JAL) begin
      is_jump_next = 1'b1;
      taken_next   = 1'b1;
      target_next  = s0_pc_reg + imm_j;
    end else if (JUMP_EN != 0 && opcode == OP_JALR) begin
      is_jump_next = 1'b1;
      if (func3 == 3'd0) begin
        taken_next  = 1'b1;
        target_next = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
      end else begin
        illegal_next = 1'b1;
      end
    end
    misaligned_next = taken_next &&
                      ((IALIGN == 4) ? (target_next[1:0] != 2'b00) : target_next[0]);
  end

  // S0 refills whenever it is empty or its entry moves into S1 this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_reg <= 1'b0;
      s0_instr_reg <= '0;
      s0_pc_reg    <= '0;
      s0_rs1_reg   <= '0;
      s0_rs2_reg   <= '0;
    end else if (flush) begin
      s0_valid_reg <= 1'b0;
    end else if (in_ready) begin
      s0_valid_reg <= in_valid;
      if (in_valid) begin
        s0_instr_reg <= in_instr;
        s0_pc_reg    <= in_pc;
        s0_rs1_reg   <= in_rs1_val;
        s0_rs2_reg   <= in_rs2_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg      <= 1'b0;
      s1_taken_reg      <= 1'b0;
      s1_is_branch_reg  <= 1'b0;
      s1_is_jump_reg    <= 1'b0;
      s1_illegal_reg    <= 1'b0;
      s1_misaligned_reg <= 1'b0;
      s1_target_reg     <= '0;
      s1_link_reg       <= '0;
      s1_br_ctrl_reg    <= '0;
      s1_rs1_reg        <= '0;
      s1_rs2_reg        <= '0;
      s1_rd_reg         <= '0;
    end else if (flush) begin
      s1_valid_reg <= 1'b0;
    end else if (s1_load) begin
      s1_valid_reg <= s0_valid_reg;
      if (s0_valid_reg) begin
        s1_taken_reg      <= taken_next;
        s1_is_branch_reg  <= is_branch_next;
        s1_is_jump_reg    <= is_jump_next;
        s1_illegal_reg    <= illegal_next;
        s1_misaligned_reg <= misaligned_next;
        s1_target_reg     <= target_next;
        s1_link_reg       <= link_next;
        s1_br_ctrl_reg    <= br_ctrl_next;
        s1_rs1_reg        <= s0_instr_reg[19:15];
        s1_rs2_reg        <= s0_instr_reg[24:20];
        s1_rd_reg         <= s0_instr_reg[11:7];
      end
    end
  end

  // Counters retire on the output handshake and stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_branch_reg <= '0;
      cnt_taken_reg  <= '0;
    end else if (!flush && s1_valid_reg && out_ready) begin
      if (s1_is_branch_reg && !s1_illegal_reg && cnt_branch_reg != '1)
        cnt_branch_reg <= cnt_branch_reg + CNT_W'(1);
      if (s1_taken_reg && cnt_taken_reg != '1)
        cnt_taken_reg <= cnt_taken_reg + CNT_W'(1);
    end
  end

  assign out_valid      = s1_valid_reg;
  assign out_taken      = s1_taken_reg;
  assign out_target     = s1_target_reg;
  assign out_link       = s1_link_reg;
  assign out_is_branch  = s1_is_branch_reg;
  assign out_is_jump    = s1_is_jump_reg;
  assign out_br_ctrl    = s1_br_ctrl_reg;
  assign out_rs1        = s1_rs1_reg;
  assign out_rs2        = s1_rs2_reg;
  assign out_rd         = s1_rd_reg;
  assign out_illegal    = s1_illegal_reg;
  assign out_misaligned = s1_misaligned_reg;
  assign cnt_branch     = cnt_branch_reg;
  assign cnt_taken      = cnt_taken_reg;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, pipelined successor to the combinational branch decoder.
- Decodes conditional branches (B-type), JAL and JALR, compares operands, and computes taken, target, link address and misalignment.
- Two-stage valid/ready pipeline between decode and fetch-redirect logic, with flush and saturating performance counters.

Parameters:
- XLEN, 32, operand/PC width (32 or 64).
- JUMP_EN, 1, 1 = decode JAL/JALR; 0 = treat them as non-control.
- IALIGN, 4, instruction alignment in bytes (4, or 2 for compressed support); drives the misalignment check.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  drop all in-flight entries
- in_valid  in  1  input entry valid
- in_ready  out  1  unit can accept an input entry
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- in_rs1_val  in  XLEN  rs1 operand value
- in_rs2_val  in  XLEN  rs2 operand value
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_taken  out  1  redirect required
- out_target  out  XLEN  redirect target; pc+4 when not taken
- out_link  out  XLEN  pc+4
- out_is_branch  out  1  conditional branch
- out_is_jump  out  1  JAL/JALR
- out_br_ctrl  out  3  branch_control code (`BEQ..`BGEU, `BR_NOP) from processor_defines
- out_rs1, out_rs2, out_rd  out  5 each  register fields
- out_illegal  out  1  reserved func3 on a control opcode
- out_misaligned  out  1  taken target violates IALIGN
- cnt_branch  out  CNT_W  retired conditional branches
- cnt_taken  out  CNT_W  retired taken branches and jumps

Behaviour:
- Reset: all valids 0, every output 0, counters 0. A reset asserted mid-operation discards all entries.
- Stage S0 registers the input when in_valid && in_ready.
- Stage S1 holds the computed result; out_* are driven directly from S1 registers.
- Latency: an entry accepted at edge N is presented with out_valid=1 after edge N+1.
- Pipeline advance:
  - S1 loads when !s1_valid || out_ready.
  - S0 advances when the S1 load condition holds.
  - in_ready = !s0_valid || S0 advances, so full throughput is one entry per cycle.
- Output hold: while out_valid && !out_ready, all out_* stay stable.
- Flush: on the edge where flush=1, both valids clear. The input presented that cycle is dropped, and no counters update for that cycle. rst has priority over flush.
- Opcode 1100011 (branch):
  - imm = sext({i[31], i[7], i[30:25], i[11:8], 0}).
  - func3 0/1/4/5/6/7 → BEQ/BNE/BLT/BGE/BLTU/BGEU. BLT/BGE compare signed; BLTU/BGEU compare unsigned.
  - func3 2/3 → out_illegal=1, br_ctrl=`BR_NOP, taken=0.
  - out_is_branch=1.
- Opcode 1101111 (JAL, JUMP_EN=1): taken=1, target = pc + sext(J-imm), rd valid.
- Opcode 1100111 (JALR, JUMP_EN=1):
  - func3 = 0: taken=1, target = (rs1 + sext(I-imm)) & ~1.
  - func3 ≠ 0: out_illegal=1, taken=0.
- Any other opcode: pass-through with is_branch=0, is_jump=0, taken=0, target=pc+4, br_ctrl=`BR_NOP.
- Arithmetic: all adds are modulo 2^XLEN (wrap silently). Immediates are sign-extended to XLEN.
- Misalignment:
  - out_misaligned = taken && (IALIGN==4 ? target[1:0]≠0 : target[0]≠0).
  - taken and target remain as computed; the trap decision is downstream.
- Counters:
  - Update only on an out_valid && out_ready handshake.
  - cnt_branch increments when is_branch && !illegal.
  - cnt_taken increments when taken.
  - Both saturate at all-ones and never wrap.

Test Plan:
- BEQ, imm=+16, pc=0x100, rs1=rs2=5 → taken=1, target=0x110, link=0x104, cnt_branch=1, cnt_taken=1, latency 2 cycles.
- BLT vs BLTU with rs1=0xFFFFFFFF, rs2=1 → BLT taken=1; BLTU taken=0, target=pc+4.
- Back-to-back 4 branches with out_ready held 0 for 3 cycles → in_ready drops after 2 entries, out_* stable, all 4 delivered in order, none lost or duplicated.
- flush asserted with S0 and S1 full plus a new input present → next cycle out_valid=0, counters unchanged, next accepted entry emerges normally.
- JALR rs1=0x1001, imm=2 → target=0x1002 (bit0 cleared), misaligned=1 for IALIGN=4, 0 for IALIGN=2; func3=1 → illegal=1, taken=0.
- pc=0xFFFFFFFC, BNE with imm=+8 taken → target=0x4 (wraps). With CNT_W=2, 5 taken branches → cnt_taken=3 (saturated).
